conv_window_gen: RTL and testbench

Streaming 5×5 window generator that feeds the 5×5 MAC convolution block. It accepts a raster-order stream of 9-bit signed pixels and buffers four previous image rows. For every valid 5×5 neighbourhood it presents the window as five 45-bit packed columns with a one-cycle `x_valid` pulse. It holds that window stable for the five cycles the convolution block spends walking it, and back-pressures the pixel source meanwhile.

---
 rtl/conv_window_gen_pkg.sv | 17 +
 rtl/line_buffer.sv | 35 +++
 rtl/conv_window_gen.sv | 172 +++++++++++++++++
 tb/tb_conv_window_gen.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_gen_pkg.sv
// Shared CNN definitions for the 5x5 window generator: pixel width,
// kernel size, packed column width and the handshake FSM states.
package conv_window_gen_pkg;

    localparam int DW    = 9;
    localparam int KSIZE = 5;
    localparam int COLW  = KSIZE * DW;

    // A window is held for four cycles (hcnt 0..3) before the source may resume.
    localparam logic [1:0] HOLD_LAST = 2'd3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/line_buffer.sv
// One image row of delay: a DEPTH-deep circular store addressed by column.
// The read is registered and prefetched, so the caller presents the address
// the next transfer will use; the old pixel at that column is then ready on
// dout_o when the transfer happens, while the new pixel overwrites the slot.
module line_buffer #(
    parameter int DEPTH = 28,
    parameter int DW    = 9,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] dout_q;

    // Store the pixel arriving at the current column, replacing last row's value.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[wr_addr_i] <= din_i;
        end
    end

    // Prefetch the column the next transfer will consume; rd != wr whenever en_i is high.
    always_ff @(posedge clk) begin
        dout_q <= mem_q[rd_addr_i];
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 5x5 window generator. Pixels arrive in raster order; four line
// buffers supply the rows above, a 5x5 window register shifts in one column
// per transfer, and each complete neighbourhood is presented on x_m_1..x_m_5
// for five cycles while the pixel source is stalled.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = conv_window_gen_pkg::DW
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                pix_valid,
    input  logic [DW-1:0]       pix_data,
    output logic                pix_ready,
    output logic                x_valid,
    output logic [KSIZE*DW-1:0] x_m_1,
    output logic [KSIZE*DW-1:0] x_m_2,
    output logic [KSIZE*DW-1:0] x_m_3,
    output logic [KSIZE*DW-1:0] x_m_4,
    output logic [KSIZE*DW-1:0] x_m_5,
    output logic                frame_done
);

    localparam int XW = KSIZE * DW;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KSIZE - 1);

    state_e          state_q;
    logic [1:0]      hcnt_q;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            x_valid_q;
    logic            frame_done_q;

    // win_q keeps the four most recent columns; win_d is the full window
    // including the column being shifted in by the current transfer.
    logic [XW-1:0]   win_q  [KSIZE-1];
    logic [XW-1:0]   win_d  [KSIZE];
    logic [XW-1:0]   xm_q   [KSIZE];

    logic [DW-1:0]   lb_in  [KSIZE-1];
    logic [DW-1:0]   lb_out [KSIZE-1];
    logic [XW-1:0]   new_col;

    logic            xfer;
    logic            win_ok;
    logic            frame_last;

    assign xfer       = pix_valid && (state_q == ST_RUN);
    assign win_ok     = xfer && (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);
    assign frame_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Raster position after this cycle's transfer (if any).
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (xfer) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Line buffer chain lb1..lb4: each stage delays the previous stage by one row.
    // The packed column places the current pixel at the bottom and the oldest row on top.
    assign new_col[DW-1:0] = pix_data;

    genvar gi;
    generate
        for (gi = 0; gi < KSIZE - 1; gi++) begin : g_lb
            if (gi == 0) begin : g_first
                assign lb_in[gi] = pix_data;
            end else begin : g_chain
                assign lb_in[gi] = lb_out[gi-1];
            end

            line_buffer #(
                .DEPTH (IMG_W),
                .DW    (DW)
            ) u_lb (
                .clk       (clk),
                .en_i      (xfer),
                .wr_addr_i (col_q),
                .rd_addr_i (col_d),
                .din_i     (lb_in[gi]),
                .dout_o    (lb_out[gi])
            );

            assign new_col[(gi+1)*DW +: DW] = lb_out[gi];
            assign win_d[gi] = win_q[gi];

            // Shift the window one column left on every transfer.
            always_ff @(posedge clk) begin
                if (xfer) begin
                    win_q[gi] <= win_d[gi+1];
                end
            end
        end

        assign win_d[KSIZE-1] = new_col;

        for (gi = 0; gi < KSIZE; gi++) begin : g_out
            // Capture the completed window only when it is a valid neighbourhood.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    xm_q[gi] <= '0;
                end else if (win_ok) begin
                    xm_q[gi] <= win_d[gi];
                end
            end
        end
    endgenerate

    // Position counters and RUN/HOLD handshake FSM with registered pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_RUN;
            hcnt_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            x_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            x_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (win_ok) begin
                        state_q      <= ST_HOLD;
                        hcnt_q       <= '0;
                        x_valid_q    <= 1'b1;
                        frame_done_q <= frame_last;
                    end
                end
                ST_HOLD: begin
                    if (hcnt_q == HOLD_LAST) begin
                        state_q <= ST_RUN;
                        hcnt_q  <= '0;
                    end else begin
                        hcnt_q  <= hcnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Ready depends on the state register alone, never on pix_valid.
    assign pix_ready  = (state_q == ST_RUN);
    assign x_valid    = x_valid_q;
    assign frame_done = frame_done_q;
    assign x_m_1      = xm_q[0];
    assign x_m_2      = xm_q[1];
    assign x_m_3      = xm_q[2];
    assign x_m_4      = xm_q[3];
    assign x_m_5      = xm_q[4];

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on an 8x8 frame: window contents,
// hold timing, stalls, signed data, back-to-back frames and reset in HOLD.
module tb_conv_window_gen;
    import conv_window_gen_pkg::*;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 4) * (H - 4);

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            pix_valid = 1'b0;
    logic [DW-1:0]   pix_data = '0;
    logic            pix_ready;
    logic            x_valid;
    logic            frame_done;
    logic [COLW-1:0] x_m_1, x_m_2, x_m_3, x_m_4, x_m_5;
    logic [COLW-1:0] xm [KSIZE];
    logic [DW-1:0]   pix_mem [NPIX];

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    assign xm[0] = x_m_1;
    assign xm[1] = x_m_2;
    assign xm[2] = x_m_3;
    assign xm[3] = x_m_4;
    assign xm[4] = x_m_5;

    conv_window_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (DW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .x_valid    (x_valid),
        .x_m_1      (x_m_1),
        .x_m_2      (x_m_2),
        .x_m_3      (x_m_3),
        .x_m_4      (x_m_4),
        .x_m_5      (x_m_5),
        .frame_done (frame_done)
    );

    // Expected packed column: row r-4 in the top slice down to row r at the bottom.
    function automatic logic [COLW-1:0] exp_column(input int r, input int c);
        logic [COLW-1:0] v;
        v = '0;
        for (int k = 0; k < KSIZE; k++) begin
            v[COLW-1-k*DW -: DW] = pix_mem[(r - 4 + k) * W + c];
        end
        return v;
    endfunction

    task automatic fill_pattern(input int base);
        for (int i = 0; i < NPIX; i++) begin
            pix_mem[i] = DW'(base + i);
        end
    endtask

    task automatic check_reset_values(input string tag);
        vec_cnt++;
        if (pix_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s pix_ready: got %b expected 1", tag, pix_ready);
        end
        vec_cnt++;
        if (x_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s x_valid: got %b expected 0", tag, x_valid);
        end
        vec_cnt++;
        if (frame_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s frame_done: got %b expected 0", tag, frame_done);
        end
        for (int j = 0; j < KSIZE; j++) begin
            vec_cnt++;
            if (xm[j] !== '0) begin
                err_cnt++;
                $display("FAIL %s x_m_%0d: got %h expected 0", tag, j + 1, xm[j]);
            end
        end
    endtask

    // Stream one full frame from pix_mem and check every window, pulse and hold cycle.
    task automatic run_frame(input string tag, input bit stall, input bit chk_spacing,
                             output int first_idx);
        int              idx, wins, age, cyc, last_pulse, er, ec;
        bit              in_hold, done;
        logic [COLW-1:0] snap [KSIZE];
        logic [COLW-1:0] exp_col;
        idx = 0; wins = 0; age = 0; cyc = 0; last_pulse = -100;
        in_hold = 1'b0; done = 1'b0; first_idx = -1;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (x_valid === 1'b1) begin
                wins++;
                if (first_idx < 0) first_idx = idx;
                er = 4 + (wins - 1) / (W - 4);
                ec = 4 + (wins - 1) % (W - 4);
                for (int j = 0; j < KSIZE; j++) begin
                    exp_col = exp_column(er, ec - 4 + j);
                    vec_cnt++;
                    if (xm[j] !== exp_col) begin
                        err_cnt++;
                        $display("FAIL %s win%0d x_m_%0d: got %h expected %h",
                                 tag, wins, j + 1, xm[j], exp_col);
                    end
                    snap[j] = xm[j];
                end
                vec_cnt++;
                if (frame_done !== (wins == NWIN)) begin
                    err_cnt++;
                    $display("FAIL %s win%0d frame_done: got %b expected %b",
                             tag, wins, frame_done, (wins == NWIN));
                end
                vec_cnt++;
                if (pix_ready !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL %s win%0d pix_ready at pulse: got %b expected 0",
                             tag, wins, pix_ready);
                end
                if (chk_spacing && ec > 4) begin
                    vec_cnt++;
                    if (cyc - last_pulse != 5) begin
                        err_cnt++;
                        $display("FAIL %s win%0d spacing: got %0d expected 5",
                                 tag, wins, cyc - last_pulse);
                    end
                end
                last_pulse = cyc;
                age = 0;
                in_hold = 1'b1;
            end else begin
                vec_cnt++;
                if (frame_done !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL %s stray frame_done: got %b expected 0", tag, frame_done);
                end
                if (in_hold) begin
                    age++;
                    for (int j = 0; j < KSIZE; j++) begin
                        vec_cnt++;
                        if (xm[j] !== snap[j]) begin
                            err_cnt++;
                            $display("FAIL %s hold age%0d x_m_%0d: got %h expected %h",
                                     tag, age, j + 1, xm[j], snap[j]);
                        end
                    end
                    vec_cnt++;
                    if (pix_ready !== (age == 4)) begin
                        err_cnt++;
                        $display("FAIL %s hold age%0d pix_ready: got %b expected %b",
                                 tag, age, pix_ready, (age == 4));
                    end
                    if (age == 4) in_hold = 1'b0;
                end
            end
            if (wins >= NWIN && !in_hold) begin
                done = 1'b1;
            end else if (cyc > 1500) begin
                err_cnt++;
                $display("FAIL %s timeout: got %0d windows expected %0d", tag, wins, NWIN);
                done = 1'b1;
            end
            if (!done && idx < NPIX && (!stall || $urandom_range(0, 1) == 1)) begin
                pix_valid = 1'b1;
                pix_data  = pix_mem[idx];
                if (pix_ready === 1'b1) idx++;
            end else begin
                pix_valid = 1'b0;
            end
        end
        pix_valid = 1'b0;
        vec_cnt++;
        if (wins != NWIN) begin
            err_cnt++;
            $display("FAIL %s window count: got %0d expected %0d", tag, wins, NWIN);
        end
        vec_cnt++;
        if (idx != NPIX) begin
            err_cnt++;
            $display("FAIL %s pixels consumed: got %0d expected %0d", tag, idx, NPIX);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_held");
        rstn = 1'b1;
        @(negedge clk);
        check_reset_values("reset_released");
    endtask

    task automatic test_tiny_frame();
        int first_idx;
        fill_pattern(0);
        run_frame("tiny", 1'b0, 1'b1, first_idx);
        vec_cnt++;
        if (first_idx != 4 * W + 5) begin
            err_cnt++;
            $display("FAIL tiny first pulse pixels: got %0d expected %0d", first_idx, 4 * W + 5);
        end
    endtask

    task automatic test_random_stalls();
        int first_idx;
        fill_pattern(0);
        run_frame("stalls", 1'b1, 1'b0, first_idx);
    endtask

    task automatic test_signed();
        int first_idx;
        for (int i = 0; i < NPIX; i++) begin
            case (i % 3)
                0:       pix_mem[i] = 9'h100;
                1:       pix_mem[i] = 9'h0FF;
                default: pix_mem[i] = DW'(i);
            endcase
        end
        run_frame("signed", 1'b0, 1'b1, first_idx);
    endtask

    task automatic test_back_to_back();
        int first_idx;
        fill_pattern(100);
        run_frame("b2b_f1", 1'b0, 1'b1, first_idx);
        fill_pattern(170);
        run_frame("b2b_f2", 1'b0, 1'b1, first_idx);
    endtask

    task automatic test_reset_mid_hold();
        int idx, cyc, first_idx;
        bit seen;
        idx = 0; cyc = 0; seen = 1'b0;
        fill_pattern(30);
        while (!seen && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (x_valid === 1'b1) begin
                seen = 1'b1;
                pix_valid = 1'b0;
            end else if (idx < NPIX) begin
                pix_valid = 1'b1;
                pix_data  = pix_mem[idx];
                if (pix_ready === 1'b1) idx++;
            end else begin
                pix_valid = 1'b0;
            end
        end
        pix_valid = 1'b0;
        vec_cnt++;
        if (!seen) begin
            err_cnt++;
            $display("FAIL rst_hold pulse before reset: got none expected one");
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_values("rst_hold_async");
        @(negedge clk);
        rstn = 1'b1;
        fill_pattern(70);
        run_frame("rst_hold_after", 1'b0, 1'b1, first_idx);
        vec_cnt++;
        if (first_idx != 4 * W + 5) begin
            err_cnt++;
            $display("FAIL rst_hold first pulse pixels: got %0d expected %0d",
                     first_idx, 4 * W + 5);
        end
    endtask

    initial begin
        test_reset();
        test_tiny_frame();
        test_random_stalls();
        test_signed();
        test_back_to_back();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
